rd_port_arb_n_to_1: RTL
=======================

# rd_port_arb_n_to_1

Parametrised, registered N-to-1 read-port arbiter for the exec register-file read path. It accepts read requests from NUM_PORTS requesters that may collide in the same cycle, and buffers each losing request in a one-deep per-port pending slot. It issues exactly one read address per cycle to the register file, with round-robin or fixed-priority selection. Downstream backpressure is honoured via `rd_stall`.

## Interface
- NUM_PORTS, 9, number of requesting ports (2..16)
- WIDTH, 9, read-address width
- PORT_ID_W, 4, width of granted-port index; must satisfy 2^PORT_ID_W >= NUM_PORTS
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- port_rd_en  in  NUM_PORTS  per-port single-cycle read request
- port_rd_addr  in  NUM_PORTS*WIDTH  packed addresses; port i at [i*WIDTH +: WIDTH]
- port_busy  out  NUM_PORTS  port i has a pending (unserved) request; it must not request again
- rd_stall  in  1  downstream cannot accept; hold output
- rd_en  out  1  registered read strobe to register file
- rd_addr  out  WIDTH  registered read address
- rd_port_id  out  PORT_ID_W  index of port whose address is on rd_addr
- overflow_err  out  1  sticky: a request arrived while that port was busy

## Operation
- Per-port state: pend_v[i], pend_addr[i]. `port_busy` = pend_v (direct register output).
- Effective request: req[i] = pend_v[i] | (port_rd_en[i] & ~pend_v[i]). Effective address is pend_addr[i] if pend_v[i], else the port_rd_addr slice.
- A request with port_rd_en[i] & pend_v[i] is dropped and sets overflow_err. The error stays set until rst.
- Grant occurs only when rd_stall=0 and |req. Exactly one winner, chosen per Configuration.
- On grant: rd_en<=1, rd_addr<=winner address, rd_port_id<=winner index. Winner's pend_v clears if set. The round-robin pointer last<=winner.
- Every non-winning fresh request (port_rd_en & ~pend_v) is captured: pend_v<=1, pend_addr<=address.
- When rd_stall=1:
  - rd_en, rd_addr and rd_port_id hold their values.
  - No grant occurs.
  - All fresh requests are captured into pending.
- When rd_stall=0 and no req: rd_en<=0. rd_addr and rd_port_id hold their values.
- Pending requests are never lost. They are served before any new request from the same port, because that port is busy.

## Timing
- Reset values:
  - rd_en=0, rd_addr=0, rd_port_id=0, overflow_err=0.
  - All pend_v=0, so port_busy=0.
  - Round-robin pointer last=NUM_PORTS-1, so port 0 has first priority.
- Latency from uncontended fresh request to rd_en: 1 cycle.
- A port that loses arbitration is busy from the next cycle. With round-robin, worst-case wait is NUM_PORTS cycles of no stall.
- port_busy falls in the cycle after that port's grant. The port may re-request in that cycle.
- Round-robin search order is last+1 … NUM_PORTS-1, 0 … last, with wrap-around at NUM_PORTS-1 → 0.
- rst mid-operation takes effect at the next edge regardless of rd_stall:
  - discards all pending requests;
  - returns all outputs to their reset values;
  - ignores requests presented in the reset cycle.
- rd_stall asserted in the same cycle as a would-be grant: no grant. Output holds the previous values.

## Configuration
- RD_PORT_ARB_ROUND_ROBIN_EN defined: round-robin selection with the rotating pointer as above.
- Not defined: fixed priority, lowest port index wins. The pointer register is not instantiated. Starvation of high-index ports is permitted.

## Test plan
- Single request: port 3 asserts rd_en with addr 0x05A, no stall → next cycle rd_en=1, rd_addr=0x05A, rd_port_id=3, port_busy=0.
- Collision: ports 0, 4, 8 request together (addrs 0x010, 0x040, 0x080), round-robin, after reset → grants over 3 cycles in order 0, 4, 8. port_busy[4] and [8] are high until their grants.
- Wrap-around: last grant is port 8 (NUM_PORTS=9); ports 0 and 8 then both request → port 0 granted first.
- Stall: a grant is on the output and rd_stall=1 for 3 cycles while port 2 requests 0x0AA → output unchanged, port_busy[2]=1. The cycle after stall drops: rd_addr=0x0AA, rd_port_id=2.
- Overflow: port 5 requests while port_busy[5]=1 → overflow_err=1 and stays 1. The original pending address is still issued.
- Reset mid-operation: 3 ports pending, assert rst for one cycle → all port_busy=0, rd_en=0, overflow_err=0. No stale grant follows. Fixed-priority build: ports 1 and 6 collide → port 1 granted first.

Source files
------------

// File: rtl/rd_port_arb_n_to_1.sv
// N-to-1 register-file read-port arbiter with one-deep per-port pending slots.
// Define RD_PORT_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module rd_port_arb_n_to_1 #(
    parameter int NUM_PORTS = 9,
    parameter int WIDTH     = 9,
    parameter int PORT_ID_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       port_rd_en,
    input  logic [NUM_PORTS*WIDTH-1:0] port_rd_addr,
    output logic [NUM_PORTS-1:0]       port_busy,
    input  logic                       rd_stall,
    output logic                       rd_en,
    output logic [WIDTH-1:0]           rd_addr,
    output logic [PORT_ID_W-1:0]       rd_port_id,
    output logic                       overflow_err
);

    logic [NUM_PORTS-1:0] pend_v;
    logic [WIDTH-1:0]     pend_addr [NUM_PORTS];
    logic [WIDTH-1:0]     eff_addr  [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] fresh;
    logic                 win_vld;
    logic [PORT_ID_W-1:0] win_idx;
    logic [WIDTH-1:0]     win_addr;
    logic                 grant;

`ifdef RD_PORT_ARB_ROUND_ROBIN_EN
    logic [PORT_ID_W-1:0] last;
`endif

    assign port_busy = pend_v;
    // A fresh request on a busy port is dropped, so it never reaches arbitration.
    assign fresh     = port_rd_en & ~pend_v;
    assign req       = pend_v | fresh;
    assign grant     = win_vld & ~rd_stall;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eff_addr[i] = pend_v[i] ? pend_addr[i] : port_rd_addr[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        win_addr = '0;
`ifdef RD_PORT_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!win_vld && req[(int'(last) + k) % NUM_PORTS]) begin
                win_vld = 1'b1;
                win_idx = PORT_ID_W'((int'(last) + k) % NUM_PORTS);
            end
        end
`else
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = PORT_ID_W'(i);
            end
        end
`endif
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win_idx == PORT_ID_W'(i)) win_addr = eff_addr[i];
        end
    end

    // Stage boundary: control state and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v       <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            rd_port_id   <= '0;
            overflow_err <= 1'b0;
`ifdef RD_PORT_ARB_ROUND_ROBIN_EN
            last         <= PORT_ID_W'(NUM_PORTS - 1);
`endif
        end else begin
            if (|(port_rd_en & pend_v)) overflow_err <= 1'b1;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant && win_idx == PORT_ID_W'(i)) pend_v[i] <= 1'b0;
                else if (fresh[i])                      pend_v[i] <= 1'b1;
            end
            if (grant) begin
                rd_en      <= 1'b1;
                rd_addr    <= win_addr;
                rd_port_id <= win_idx;
`ifdef RD_PORT_ARB_ROUND_ROBIN_EN
                last       <= win_idx;
`endif
            end else if (!rd_stall) begin
                rd_en <= 1'b0;
            end
        end
    end

    // Stage boundary: pending address slots (data only, no reset needed).
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (fresh[i] && !(grant && win_idx == PORT_ID_W'(i))) begin
                pend_addr[i] <= port_rd_addr[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule
